// File: rtl/seq_gen_tx.sv
// Serial bit-pattern transmitter: shifts a latched pattern out MSB-first with idle gaps between repeats.
// Optional even-parity bit per frame when SEQ_GEN_TX_PARITY_EN is defined.
module seq_gen_tx #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned REP_W   = 4,
  parameter int unsigned GAP_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [REP_W-1:0] reps,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [IDX_W-1:0] top_q, top_d;
  logic [IDX_W-1:0] bit_q, bit_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             out_d, valid_d, busy_d, done_d;
  logic             end_frame, load_frame;
  logic [LEN_W-1:0] len_eff;
  logic [WIDTH-1:0] mask;
`ifdef SEQ_GEN_TX_PARITY_EN
  logic             par_q, par_d;
`endif

  // Effective length: 0 or oversize selects the full pattern width
  always_comb begin
    len_eff = len;
    if ((len == '0) || (len > LEN_W'(WIDTH)))
      len_eff = LEN_W'(WIDTH);
    mask = '0;
    for (int unsigned i = 0; i < WIDTH; i++)
      if (LEN_W'(i) < len_eff)
        mask[i] = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    top_d      = top_q;
    bit_d      = bit_q;
    rep_d      = rep_q;
    gap_d      = gap_q;
    out_d      = 1'b0;
    valid_d    = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    end_frame  = 1'b0;
    load_frame = 1'b0;
`ifdef SEQ_GEN_TX_PARITY_EN
    par_d      = par_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pat_d   = pattern & mask;
          top_d   = IDX_W'(len_eff - LEN_W'(1));
          rep_d   = reps;
          gap_d   = '0;
          bit_d   = top_d;
          out_d   = pattern[top_d];
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = S_SHIFT;
`ifdef SEQ_GEN_TX_PARITY_EN
          par_d   = 1'b0;
`endif
        end
      end
      S_SHIFT: begin
        busy_d = 1'b1;
`ifdef SEQ_GEN_TX_PARITY_EN
        if (par_q) begin
          par_d     = 1'b0;
          end_frame = 1'b1;
        end else if (bit_q == '0) begin
          // Pattern is stored masked, so reduction XOR covers only frame bits
          par_d   = 1'b1;
          out_d   = ^pat_q;
          valid_d = 1'b1;
        end else begin
          bit_d   = bit_q - IDX_W'(1);
          out_d   = pat_q[bit_d];
          valid_d = 1'b1;
        end
`else
        if (bit_q == '0) begin
          end_frame = 1'b1;
        end else begin
          bit_d   = bit_q - IDX_W'(1);
          out_d   = pat_q[bit_d];
          valid_d = 1'b1;
        end
`endif
      end
      S_GAP: begin
        busy_d = 1'b1;
        if (gap_q == '0)
          load_frame = 1'b1;
        else
          gap_d = gap_q - GAP_W'(1);
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Frame finished: repeat (via gap) or conclude
    if (end_frame) begin
      if (rep_q != '0) begin
        rep_d = rep_q - REP_W'(1);
        if (GAP_CYC == 0) begin
          load_frame = 1'b1;
        end else begin
          state_d = S_GAP;
          gap_d   = GAP_W'(GAP_CYC - 1);
        end
      end else begin
        state_d = S_FIN;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
    end

    if (load_frame) begin
      state_d = S_SHIFT;
      bit_d   = top_q;
      out_d   = pat_q[top_q];
      valid_d = 1'b1;
      busy_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pat_q     <= '0;
      top_q     <= '0;
      bit_q     <= '0;
      rep_q     <= '0;
      gap_q     <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SEQ_GEN_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      top_q     <= top_d;
      bit_q     <= bit_d;
      rep_q     <= rep_d;
      gap_q     <= gap_d;
      out       <= out_d;
      out_valid <= valid_d;
      busy      <= busy_d;
      done      <= done_d;
`ifdef SEQ_GEN_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_seq_gen_tx.sv
// Bench for seq_gen_tx: fixed vector table, hand corner sequences, randomized runs vs a per-cycle model.
module tb_seq_gen_tx;
  localparam int unsigned WIDTH   = 8;
  localparam int unsigned GAP_CYC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] len = '0;
  logic [3:0] reps = '0;
  logic       out, out_valid, busy, done;

  int unsigned total = 0;
  int unsigned passed = 0;
  logic [3:0]  exp_q[$];

  typedef struct {
    logic [7:0]  pattern;
    logic [3:0]  len;
    logic [3:0]  reps;
    logic [31:0] bits;
    int          nbits;
    int          busy_cyc;
  } vec_t;

  vec_t vecs[$];

  seq_gen_tx #(.WIDTH(8), .LEN_W(4), .REP_W(4), .GAP_CYC(GAP_CYC)) dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .len(len), .reps(reps),
    .out(out), .out_valid(out_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  // Expected {out,out_valid,busy,done} for each cycle after the start edge
  task automatic build_model(input logic [7:0] p, input int l_in, input int r);
    int l;
    logic par;
    logic [7:0] tmp;
    exp_q.delete();
    l = (l_in == 0 || l_in > int'(WIDTH)) ? int'(WIDTH) : l_in;
    for (int k = 0; k <= r; k++) begin
      par = 1'b0;
      for (int i = l - 1; i >= 0; i--) begin
        tmp = p >> i;
        exp_q.push_back({tmp[0], 1'b1, 1'b1, 1'b0});
        par ^= tmp[0];
      end
`ifdef SEQ_GEN_TX_PARITY_EN
      exp_q.push_back({par, 1'b1, 1'b1, 1'b0});
`endif
      if (k < r)
        repeat (GAP_CYC) exp_q.push_back(4'b0010);
    end
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0000);
  endtask

  // mode 0: quiet inputs; 1: random input noise while busy; 2: start held + pattern FF while busy
  task automatic run_model(input string tag, input logic [7:0] p, input int l, input int r, input int mode);
    build_model(p, l, r);
    pattern = p;
    len     = 4'(l);
    reps    = 4'(r);
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j < exp_q.size(); j++) begin
      check($sformatf("%s_cyc%0d", tag, j), {28'd0, out, out_valid, busy, done}, {28'd0, exp_q[j]});
      if (j < exp_q.size() - 1) begin
        if (mode == 1) begin
          start   = 1'($urandom_range(0, 1));
          pattern = 8'($urandom);
          len     = 4'($urandom);
          reps    = 4'($urandom);
        end else if (mode == 2) begin
          start   = 1'b1;
          pattern = 8'hFF;
        end
      end else begin
        start = 1'b0;
      end
      tick();
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [31:0] bits;
    int n, bc, cyc;
    pattern = v.pattern;
    len     = v.len;
    reps    = v.reps;
    start   = 1'b1;
    tick();
    start = 1'b0;
    bits = '0; n = 0; bc = 0; cyc = 0;
    while (!done && cyc < 200) begin
      if (out_valid) begin
        bits = {bits[30:0], out};
        n++;
      end
      if (busy) bc++;
      cyc++;
      tick();
    end
    check($sformatf("vec%0d_done", idx), {31'd0, done}, 32'd1);
    check($sformatf("vec%0d_bits", idx), bits, v.bits);
    check($sformatf("vec%0d_nbits", idx), 32'(n), 32'(v.nbits));
    check($sformatf("vec%0d_busy", idx), 32'(bc), 32'(v.busy_cyc));
    tick();
    check($sformatf("vec%0d_idle", idx), {28'd0, out, out_valid, busy, done}, 32'd0);
  endtask

  initial begin
`ifdef SEQ_GEN_TX_PARITY_EN
    vecs.push_back('{8'h07, 4'd3, 4'd0, 32'b1111, 4, 4});
    vecs.push_back('{8'h05, 4'd3, 4'd0, 32'b1010, 4, 4});
    vecs.push_back('{8'hA5, 4'd0, 4'd1, 32'b101001010_101001010, 18, 20});
`else
    vecs.push_back('{8'h05, 4'd3, 4'd0, 32'b101, 3, 3});
    vecs.push_back('{8'hA5, 4'd0, 4'd0, 32'hA5, 8, 8});
    vecs.push_back('{8'h05, 4'd3, 4'd2, 32'b101101101, 9, 13});
    vecs.push_back('{8'hA5, 4'd12, 4'd1, 32'hA5A5, 16, 18});
    vecs.push_back('{8'h01, 4'd1, 4'd3, 32'b1111, 4, 10});
`endif

    #12;
    check("reset_outputs", {28'd0, out, out_valid, busy, done}, 32'd0);
    rst = 1'b1;
    tick();
    check("idle_after_reset", {28'd0, out, out_valid, busy, done}, 32'd0);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // start re-pulsed with FF during SHIFT and FIN must not disturb the stream
    run_model("ignore_ff", 8'h05, 3, 0, 2);
    run_model("ignore_ff_reps", 8'h05, 3, 1, 2);

    // Asynchronous reset in the 2nd bit of an 8-bit frame
    pattern = 8'hA5; len = 4'd8; reps = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("rst_pre_bit2", {28'd0, out, out_valid, busy, done}, {28'd0, 4'b0110});
    #2 rst = 1'b0;
    #1;
    check("rst_async_drop", {28'd0, out, out_valid, busy, done}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("rst_hold%0d", k), {28'd0, out, out_valid, busy, done}, 32'd0);
    end
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("rst_no_done%0d", k), {31'd0, done}, 32'd0);
    end
    run_model("post_rst", 8'hA5, 8, 0, 0);

    // start held high: next frame accepted on the first IDLE edge after FIN
    build_model(8'h05, 3, 0);
    exp_q.push_back(4'b1110);
    pattern = 8'h05; len = 4'd3; reps = 4'd0;
    start = 1'b1;
    tick();
    for (int j = 0; j < exp_q.size(); j++) begin
      check($sformatf("held_cyc%0d", j), {28'd0, out, out_valid, busy, done}, {28'd0, exp_q[j]});
      if (j < exp_q.size() - 1) tick();
    end
    start = 1'b0;
    for (int k = 0; k < 50 && !done; k++) tick();
    check("held_second_done", {31'd0, done}, 32'd1);
    tick();
    tick();

    for (int it = 0; it < 25; it++) begin
      logic [7:0] p;
      int l, r;
      p = 8'($urandom);
      l = int'($urandom_range(0, 15));
      r = int'($urandom_range(0, 3));
      run_model($sformatf("rnd%0d", it), p, l, r, 1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
